dmem_mmio_unit: RTL and testbench
=================================

Name: dmem_mmio_unit

Overview:
- Data-side memory stage that consumes the core's M-stage store-enable, address and store data, and returns the raw aligned load word to the W pipeline register.
- Contains the data RAM plus a small MMIO block: a 64-bit cycle counter, a console TX FIFO with a valid/ready drain port, and a tohost halt register.
- Sits directly downstream of the CPU top. Its ld_data drives the core's load-data input, and the core's load filter performs byte/half extraction and sign extension.

Parameters:
- RAM_WORDS, 4096: data RAM depth in 32-bit words; must be a power of two.
- MMIO_BASE, 32'h1000_0000: base address of the MMIO window, which spans 256 bytes.
- CON_DEPTH, 8: console FIFO depth in bytes; must be a power of two, minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- dm_w_en  in  4  byte-lane store enables from the M stage; bit i enables dm_wdata[8i+7:8i]; 0 means no store.
- dm_addr  in  32  M-stage ALU result, used as a byte address.
- dm_wdata  in  32  M-stage store data, already lane-aligned by the core.
- ld_data  out  32  aligned word at dm_addr, combinational from dm_addr.
- con_data  out  8  byte at the console FIFO head.
- con_valid  out  1  console FIFO not empty.
- con_ready  in  1  sink accepts con_data when con_valid and con_ready are both high.
- halt  out  1  tohost has been written.
- exit_code  out  32  value last written to tohost.

Behaviour:
- Clock and reset: single clock domain. rst low asynchronously clears the cycle counter, the FIFO pointers and count, the overflow flag, halt and exit_code.
  - Outputs after reset: con_valid=0, halt=0, exit_code=0. RAM contents are not reset.
- Address decode: word index = dm_addr[31:2]. dm_addr[1:0] is ignored for decode.
  - RAM region: dm_addr < RAM_WORDS*4. Index is dm_addr[log2(RAM_WORDS)+1:2].
  - MMIO region: dm_addr[31:8] == MMIO_BASE[31:8]. Offset is dm_addr[7:2].
  - Unmapped: any other address. Reads return 0; writes are ignored.
- Reads:
  - Combinational and side-effect free, because the core issues no read strobe and every M-stage address is read.
  - During a store to the same address, ld_data shows the pre-store value. The new value is visible from the cycle after the edge.
- RAM writes: at the rising edge, each lane i with dm_w_en[i]=1 is written; other lanes are unchanged.
- MMIO map (byte offset):
  - 0x00 CYCLE_LO, read-only: counter[31:0].
  - 0x04 CYCLE_HI, read-only: counter[63:32]. The counter increments every cycle from reset, wraps from 2^64-1 to 0, and ignores writes.
  - 0x08 CON_STATUS, read:
    - bit0 full.
    - bit1 empty.
    - bit2 overflow (sticky).
    - bits[12:8] count.
    - other bits 0.
  - 0x08 CON_STATUS, write: a write with dm_w_en[0]=1 and dm_wdata[2]=1 clears overflow.
  - 0x0C CON_TX, write-only, reads 0: a write with dm_w_en[0]=1 pushes dm_wdata[7:0].
  - 0x10 TOHOST, write: a write with any dm_w_en bit set latches exit_code=dm_wdata and sets halt. halt stays 1 until reset; later writes update exit_code only.
  - 0x10 TOHOST, read: returns exit_code.
  - Other offsets: read 0; writes ignored.
- Console FIFO:
  - Circular buffer with log2(CON_DEPTH)+1-bit read and write pointers; count ranges 0..CON_DEPTH.
  - Pop happens when con_valid & con_ready. con_data is the head byte and is stable while con_valid=1 and not popped.
  - Push is accepted when count < CON_DEPTH, or when count == CON_DEPTH and a pop occurs in the same cycle.
  - Rejected push: the byte is dropped, overflow is set, and count is unchanged.
  - Simultaneous accepted push and pop leave count unchanged.
  - Pointers wrap modulo 2*CON_DEPTH. full = (count == CON_DEPTH).
  - On a single-entry FIFO, the new head appears one cycle after the push edge. There is no bypass.
- Overflow set and clear in the same cycle: set wins.
- Reset mid-transfer: the FIFO empties immediately and con_valid drops asynchronously.

Test Plan:
- RAM lanes: store 32'hDEADBEEF to 0x100 with w_en=4'hF, then w_en=4'b0010 with wdata 32'h0000_5500 to 0x100. A read of 0x100 returns 32'hDEAD55EF; during the second store's cycle it shows 32'hDEADBEEF.
- Counter:
  - Release rst, then read CYCLE_LO at 10 consecutive cycles: values increment by 1.
  - A write of 0 to CYCLE_LO has no effect.
  - Force the counter to 32'hFFFF_FFFF low: CYCLE_HI increments on wrap.
- Console drain: hold con_ready=0 and push 'H' and 'i' (8'h48, 8'h69). CON_STATUS reads count=2, empty=0. Raise con_ready: con_data is 8'h48 then 8'h69 on consecutive cycles, after which con_valid=0 and status shows empty=1.
- Overflow: with con_ready=0, push CON_DEPTH+1 bytes. count=8, full=1, overflow=1, and the 9th byte is absent on drain. A write of 32'h4 to CON_STATUS clears overflow.
- Full push with pop: FIFO full and con_ready=1 with a push in the same cycle. The push is accepted, count stays 8, overflow stays 0.
- Halt and reset:
  - A write of 32'h1 to MMIO_BASE+0x10 gives halt=1, exit_code=1.
  - An unmapped address 32'h2000_0000 reads 0 and a write to it is ignored.
  - Asserting rst low mid-drain clears con_valid, halt and exit_code without waiting for a clock edge.

Source files
------------

// File: rtl/dmem_mmio_unit.sv
// dmem_mmio_unit: data-side memory stage for the core's M stage.
// Provides a byte-lane writable data RAM and a small MMIO window. The window
// holds a 64-bit cycle counter, a console TX FIFO with a valid/ready drain
// port, and a tohost halt register. All reads are combinational and have no
// side effects.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   dm_w_en    byte-lane store enables (0 = no store)
//   dm_addr    byte address (bits [1:0] ignored for decode)
//   dm_wdata   lane-aligned store data
//   ld_data    aligned word at dm_addr (combinational)
//   con_data   console FIFO head byte
//   con_valid  console FIFO not empty
//   con_ready  console sink ready
//   halt       tohost has been written
//   exit_code  last value written to tohost
module dmem_mmio_unit #(
  parameter int unsigned RAM_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter int unsigned CON_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  dm_w_en,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] ld_data,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        halt,
  output logic [31:0] exit_code
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned IDX_W  = $clog2(CON_DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;

  localparam logic [5:0] OFF_CYCLE_LO = 6'h00;
  localparam logic [5:0] OFF_CYCLE_HI = 6'h01;
  localparam logic [5:0] OFF_STATUS   = 6'h02;
  localparam logic [5:0] OFF_TX       = 6'h03;
  localparam logic [5:0] OFF_TOHOST   = 6'h04;

  logic [31:0]       ram [RAM_WORDS];
  logic [7:0]        con_mem [CON_DEPTH];
  logic [63:0]       cycle_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              con_ovf;

  logic              is_ram;
  logic              is_mmio;
  logic [RAM_AW-1:0] ram_idx;
  logic [5:0]        mmio_off;
  logic              st_any;
  logic [PTR_W-1:0]  con_count;
  logic              con_full;
  logic              con_empty;
  logic              con_pop;
  logic              con_push_req;
  logic              con_push_ok;
  logic              ovf_set;
  logic              ovf_clr;
  logic              tohost_we;
  logic [31:0]       con_status;

  // Address decode and write strobes
  always_comb begin
    is_ram       = (dm_addr[31:RAM_AW+2] == '0);
    is_mmio      = (dm_addr[31:8] == MMIO_BASE[31:8]);
    ram_idx      = dm_addr[RAM_AW+1:2];
    mmio_off     = dm_addr[7:2];
    st_any       = |dm_w_en;
    con_push_req = is_mmio && (mmio_off == OFF_TX) && dm_w_en[0];
    ovf_clr      = is_mmio && (mmio_off == OFF_STATUS) && dm_w_en[0] && dm_wdata[2];
    tohost_we    = is_mmio && (mmio_off == OFF_TOHOST) && st_any;
  end

  // Console FIFO status; count is the modular pointer difference (0..CON_DEPTH)
  always_comb begin
    con_count   = wr_ptr - rd_ptr;
    con_full    = (con_count == PTR_W'(CON_DEPTH));
    con_empty   = (con_count == '0);
    con_pop     = !con_empty && con_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    con_push_ok = con_push_req && (!con_full || con_pop);
    ovf_set     = con_push_req && !con_push_ok;
    con_valid   = !con_empty;
    con_data    = con_mem[rd_ptr[IDX_W-1:0]];
  end

  always_comb begin
    con_status       = '0;
    con_status[0]    = con_full;
    con_status[1]    = con_empty;
    con_status[2]    = con_ovf;
    con_status[12:8] = 5'(con_count);
  end

  // Side-effect-free read mux; unmapped addresses and offsets read 0
  always_comb begin
    ld_data = '0;
    if (is_ram) begin
      ld_data = ram[ram_idx];
    end else if (is_mmio) begin
      case (mmio_off)
        OFF_CYCLE_LO: ld_data = cycle_cnt[31:0];
        OFF_CYCLE_HI: ld_data = cycle_cnt[63:32];
        OFF_STATUS:   ld_data = con_status;
        OFF_TOHOST:   ld_data = exit_code;
        default:      ld_data = '0;
      endcase
    end
  end

  // Data RAM, per-lane write; contents are not reset
  always_ff @(posedge clk) begin
    if (is_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (dm_w_en[i]) ram[ram_idx][8*i +: 8] <= dm_wdata[8*i +: 8];
      end
    end
  end

  // Console FIFO storage
  always_ff @(posedge clk) begin
    if (con_push_ok) con_mem[wr_ptr[IDX_W-1:0]] <= dm_wdata[7:0];
  end

  // Counter, FIFO pointers, overflow flag and tohost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      con_ovf   <= 1'b0;
      halt      <= 1'b0;
      exit_code <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (con_push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (con_pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      // Set wins over clear
      if (ovf_set)      con_ovf <= 1'b1;
      else if (ovf_clr) con_ovf <= 1'b0;
      if (tohost_we) begin
        halt      <= 1'b1;
        exit_code <= dm_wdata;
      end
    end
  end

  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, dm_addr[1:0]};

endmodule

// File: tb/tb_dmem_mmio_unit.sv
// Testbench for dmem_mmio_unit: table of RAM/decode vectors plus hand-written
// sequences for the counter, console FIFO, tohost and asynchronous reset.
// Console bytes are checked through a queue of expected bytes filled as
// pushes are issued and drained as the sink accepts them.
module tb_dmem_mmio_unit;

  localparam logic [31:0] MMIO      = 32'h1000_0000;
  localparam logic [31:0] A_CYC_LO  = MMIO + 32'h00;
  localparam logic [31:0] A_CYC_HI  = MMIO + 32'h04;
  localparam logic [31:0] A_STATUS  = MMIO + 32'h08;
  localparam logic [31:0] A_TX      = MMIO + 32'h0C;
  localparam logic [31:0] A_TOHOST  = MMIO + 32'h10;

  logic        clk;
  logic        rst;
  logic [3:0]  dm_w_en;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] ld_data;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready;
  logic        halt;
  logic [31:0] exit_code;

  dmem_mmio_unit dut (
    .clk       (clk),
    .rst       (rst),
    .dm_w_en   (dm_w_en),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .ld_data   (ld_data),
    .con_data  (con_data),
    .con_valid (con_valid),
    .con_ready (con_ready),
    .halt      (halt),
    .exit_code (exit_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  typedef struct packed {
    logic        chk;
    logic [3:0]  w_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_ld;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's M-stage inputs at the falling edge, settle, return
  task automatic apply(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    dm_w_en  = w;
    dm_addr  = a;
    dm_wdata = d;
    #1;
  endtask

  // Sink side: every accepted byte must match the oldest expected byte
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      #2;
      if (rst && con_valid && con_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL con_pop: got unexpected byte %h expected none", con_data);
        end else begin
          exp_b = exp_q.pop_front();
          chk("con_data", 32'(con_data), 32'(exp_b));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b1, 4'h2, 32'h0000_0100, 32'h0000_5500, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 4'h0, 32'h0000_0100, 32'h0,         32'hDEAD_55EF};
    vecs[3]  = '{1'b1, 4'h0, 32'h0000_0103, 32'h0,         32'hDEAD_55EF};
    vecs[4]  = '{1'b0, 4'hF, 32'h0000_3FFC, 32'h1234_5678, 32'h0};
    vecs[5]  = '{1'b1, 4'h0, 32'h0000_3FFC, 32'h0,         32'h1234_5678};
    vecs[6]  = '{1'b1, 4'h8, 32'h0000_3FFC, 32'hAB00_0000, 32'h1234_5678};
    vecs[7]  = '{1'b1, 4'h0, 32'h0000_3FFC, 32'h0,         32'hAB34_5678};
    vecs[8]  = '{1'b0, 4'hF, 32'h0000_0000, 32'h0,         32'h0};
    vecs[9]  = '{1'b1, 4'hF, 32'h0000_4000, 32'hCAFE_F00D, 32'h0};
    vecs[10] = '{1'b1, 4'h0, 32'h0000_0000, 32'h0,         32'h0};
    vecs[11] = '{1'b1, 4'hF, 32'h2000_0000, 32'hFFFF_FFFF, 32'h0};
    vecs[12] = '{1'b1, 4'h0, 32'h2000_0000, 32'h0,         32'h0};
    vecs[13] = '{1'b1, 4'h0, A_TX,          32'h0,         32'h0};
    vecs[14] = '{1'b1, 4'hF, MMIO + 32'h14, 32'hFFFF_FFFF, 32'h0};
    vecs[15] = '{1'b1, 4'h0, A_STATUS,      32'h0,         32'h0000_0002};
    vecs[16] = '{1'b1, 4'h0, MMIO + 32'h100, 32'h0,        32'h0};

    rst       = 1'b0;
    dm_w_en   = '0;
    dm_addr   = A_CYC_LO;
    dm_wdata  = '0;
    con_ready = 1'b0;
    #1;
    chk("rst_con_valid", 32'(con_valid), 32'h0);
    chk("rst_halt", 32'(halt), 32'h0);
    chk("rst_exit_code", exit_code, 32'h0);
    chk("rst_cycle_lo", ld_data, 32'h0);
    @(negedge clk);
    @(negedge clk);

    // Counter: counts from 0 after release, one per cycle, ignores writes
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("cyc_start", ld_data, 32'h0);
    for (int i = 1; i <= 10; i++) begin
      apply(4'h0, A_CYC_LO, 32'h0);
      chk($sformatf("cyc_%0d", i), ld_data, 32'(i));
    end
    apply(4'hF, A_CYC_LO, 32'h0);
    chk("cyc_wr_pre", ld_data, 32'd11);
    apply(4'h0, A_CYC_LO, 32'h0);
    chk("cyc_wr_ignored", ld_data, 32'd12);
    apply(4'h0, A_CYC_HI, 32'h0);
    chk("cyc_hi_zero", ld_data, 32'h0);

    // Counter carry into the high word
    @(negedge clk);
    force dut.cycle_cnt = 64'h0000_0005_FFFF_FFFF;
    #1;
    chk("cyc_hi_forced", ld_data, 32'h5);
    @(negedge clk);
    #1;
    release dut.cycle_cnt;
    @(negedge clk);
    #1;
    chk("cyc_hi_wrap", ld_data, 32'h6);
    dm_addr = A_CYC_LO;
    #1;
    chk("cyc_lo_wrap", 32'(ld_data < 32'd4), 32'h1);

    // RAM lanes and address decode
    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].w_en, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chk) chk($sformatf("vec%0d", i), ld_data, vecs[i].exp_ld);
    end

    // Console drain of two bytes
    apply(4'h1, A_TX, 32'h48);
    exp_q.push_back(8'h48);
    apply(4'h1, A_TX, 32'h69);
    exp_q.push_back(8'h69);
    apply(4'h0, A_STATUS, 32'h0);
    chk("con2_status", ld_data, 32'h0000_0200);
    chk("con2_valid", 32'(con_valid), 32'h1);
    chk("con2_head", 32'(con_data), 32'h48);
    con_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("con2_valid_end", 32'(con_valid), 32'h0);
    chk("con2_status_end", ld_data, 32'h0000_0002);
    chk("con2_q_empty", 32'(exp_q.size()), 32'h0);
    con_ready = 1'b0;

    // Overflow: ninth byte dropped, flag sticky until cleared
    for (int i = 0; i < 9; i++) begin
      apply(4'h1, A_TX, 32'(8'hA0 + 8'(i)));
      if (i < 8) exp_q.push_back(8'hA0 + 8'(i));
    end
    apply(4'h0, A_STATUS, 32'h0);
    chk("ovf_status", ld_data, 32'h0000_0805);
    apply(4'h1, A_STATUS, 32'h4);
    chk("ovf_clr_pre", ld_data, 32'h0000_0805);
    apply(4'h0, A_STATUS, 32'h0);
    chk("ovf_clr_post", ld_data, 32'h0000_0801);

    // Push into a full FIFO while the head is popped
    apply(4'h1, A_TX, 32'hB0);
    con_ready = 1'b1;
    exp_q.push_back(8'hB0);
    apply(4'h0, A_STATUS, 32'h0);
    chk("fullpp_status", ld_data, 32'h0000_0801);
    begin
      int waited;
      waited = 0;
      while (con_valid && waited < 20) begin
        @(negedge clk);
        #3;
        waited++;
      end
    end
    chk("fullpp_drained", 32'(con_valid), 32'h0);
    chk("fullpp_q_empty", 32'(exp_q.size()), 32'h0);
    chk("fullpp_status_end", ld_data, 32'h0000_0002);
    con_ready = 1'b0;

    // Tohost: halt latches, later writes update exit_code only
    apply(4'h1, A_TOHOST, 32'h1);
    chk("halt_pre", 32'(halt), 32'h0);
    chk("tohost_pre", ld_data, 32'h0);
    apply(4'h0, A_TOHOST, 32'h0);
    chk("halt_set", 32'(halt), 32'h1);
    chk("exit_code_1", exit_code, 32'h1);
    chk("tohost_rd", ld_data, 32'h1);
    apply(4'h8, A_TOHOST, 32'h55);
    apply(4'h0, A_TOHOST, 32'h0);
    chk("halt_stays", 32'(halt), 32'h1);
    chk("exit_code_55", exit_code, 32'h55);

    // Asynchronous reset in the middle of a drain
    apply(4'h1, A_TX, 32'h31);
    exp_q.push_back(8'h31);
    apply(4'h1, A_TX, 32'h32);
    exp_q.push_back(8'h32);
    apply(4'h0, A_STATUS, 32'h0);
    con_ready = 1'b1;
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_con_valid", 32'(con_valid), 32'h0);
    chk("arst_halt", 32'(halt), 32'h0);
    chk("arst_exit_code", exit_code, 32'h0);
    chk("arst_status", ld_data, 32'h0000_0002);
    @(negedge clk);
    rst = 1'b1;
    con_ready = 1'b0;
    apply(4'h0, A_TOHOST, 32'h0);
    chk("arst_tohost_rd", ld_data, 32'h0);
    chk("arst_valid_after", 32'(con_valid), 32'h0);
    chk("final_q_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
